// File: rtl/rr_ring_arbiter_pkg.sv
// Shared definitions for the round-robin ring arbiter: FSM state
// encodings and the default sizing used by the top level.
package rr_ring_arbiter_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_IDW      = 2;
    localparam int DEF_MAX_HOLD = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_ring_arbiter_ring_ptr.sv
// One-hot priority pointer for the ring arbiter. On advance it loads the
// position one above the supplied one-hot winner (with wrap); reset puts
// the pointer on bit 0.
module ring_ptr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic [N-1:0] from,
    output logic [N-1:0] ptr
);

    logic [N-1:0] ptr_r;

    // Pointer register: reset to bit 0, rotate past the winner on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {{(N-1){1'b0}}, 1'b1};
        end else if (advance) begin
            ptr_r <= {from[N-2:0], from[N-1]};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// A one-hot ring pointer gives first priority; the winner holds a
// registered one-hot grant until done or until it withdraws its request,
// after which one forced idle cycle (GAP) separates it from the next grant.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD grant cycles and pulses timeout.
module rr_ring_arbiter
    import rr_ring_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDW      = DEF_IDW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    arb_state_e     state_r;
    arb_state_e     state_nxt_s;
    logic [N-1:0]   gnt_r;
    logic [IDW-1:0] gnt_id_r;
    logic           busy_r;
    logic           timeout_r;

    logic [N-1:0]   ptr_s;
    logic [IDW-1:0] ptr_idx_s;
    logic           pick_valid_s;
    logic [IDW-1:0] pick_id_s;
    logic [N-1:0]   pick_onehot_s;
    logic           withdraw_s;
    logic           force_s;
    logic           release_s;
    logic           advance_s;
    logic           timeout_hit_s;

    ring_ptr #(.N(N)) u_ring_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (advance_s),
        .from    (gnt_r),
        .ptr     (ptr_s)
    );

    // Encode the one-hot pointer into a binary start index for the scan.
    always_comb begin
        ptr_idx_s = {IDW{1'b0}};
        for (int i = 0; i < N; i++) begin
            ptr_idx_s = ptr_idx_s | (ptr_s[i] ? IDW'(i) : {IDW{1'b0}});
        end
    end

    // Priority pick: first requester at or above the pointer, wrapping around.
    // Scanning offsets from high to low lets the smallest offset win.
    always_comb begin : pick_blk
        logic [IDW:0] pos_v;
        pick_valid_s = |req;
        pick_id_s    = {IDW{1'b0}};
        pos_v        = {(IDW+1){1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            pos_v = {1'b0, ptr_idx_s} + (IDW+1)'(k);
            if (pos_v >= (IDW+1)'(N)) begin
                pos_v = pos_v - (IDW+1)'(N);
            end else begin
                pos_v = pos_v;
            end
            if (req[pos_v[IDW-1:0]]) begin
                pick_id_s = pos_v[IDW-1:0];
            end else begin
                pick_id_s = pick_id_s;
            end
        end
    end

    // One-hot form of the picked requester, loaded into gnt on a new grant.
    always_comb begin
        pick_onehot_s            = {N{1'b0}};
        pick_onehot_s[pick_id_s] = pick_valid_s;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_cnt_r;

    // Hold counter: counts grant cycles, cleared on every release and on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= {HCW{1'b0}};
        end else if ((state_r == ST_GRANT) && !release_s) begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
        end else begin
            hold_cnt_r <= {HCW{1'b0}};
        end
    end

    assign force_s = (state_r == ST_GRANT) && (hold_cnt_r == HCW'(MAX_HOLD - 1));
`else
    assign force_s = 1'b0;
`endif

    assign withdraw_s    = ~|(req & gnt_r);
    // A timeout is reported only when nothing else would have released the grant.
    assign timeout_hit_s = force_s & ~done & ~withdraw_s;

    // Next-state logic and release decision.
    always_comb begin
        state_nxt_s = state_r;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                release_s = done | withdraw_s | force_s;
                if (release_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign advance_s = release_s;

    // State register and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= {N{1'b0}};
            gnt_id_r  <= {IDW{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r    <= pick_onehot_s;
                        gnt_id_r <= pick_id_s;
                        busy_r   <= 1'b1;
                    end else begin
                        gnt_r  <= {N{1'b0}};
                        busy_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        gnt_r     <= {N{1'b0}};
                        busy_r    <= 1'b0;
                        timeout_r <= timeout_hit_s;
                    end else begin
                        gnt_r  <= gnt_r;
                        busy_r <= busy_r;
                    end
                end
                default: begin
                    gnt_r  <= {N{1'b0}};
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Self-checking bench for rr_ring_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbitration rules.
module tb_rr_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int n_checks;
    int n_fail;

    // Behavioural model: who holds the resource, where priority starts, etc.
    int m_ptr;
    int m_win;
    int m_hold;
    bit m_busy;
    bit m_gap;
    bit m_to;

    rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_busy) v[m_win] = 1'b1;
        return v;
    endfunction

    // Advance one clock; the model applies the rules to the inputs seen at the edge.
    task automatic tick();
        int idx;
        @(posedge clk);
        m_to = 1'b0;
        if (rst) begin
            m_ptr = 0; m_busy = 1'b0; m_gap = 1'b0; m_hold = 0;
        end else if (m_busy) begin
            m_hold = m_hold + 1;
            if (done || !req[m_win] || (TMO_EN && m_hold == MAX_HOLD)) begin
                m_to   = TMO_EN && (m_hold == MAX_HOLD) && !done && req[m_win];
                m_busy = 1'b0;
                m_gap  = 1'b1;
                m_hold = 0;
                m_ptr  = (m_win + 1) % N;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!m_busy && req[idx]) begin
                    m_win  = idx;
                    m_busy = 1'b1;
                    m_hold = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b busy=%b id=%0d to=%b, want 0000/0/0/0", gnt, busy, gnt_id, timeout);
        end
        for (int i = 0; i < 6; i++) begin
            done = 1'(i % 2);
            tick();
            n_checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_done_ignored: gnt=%b busy=%b, want 0000/0", gnt, busy);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b id=%0d busy=%b, want 0100/2/1", gnt, gnt_id, busy);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_hold: gnt=%b, want 0100", gnt);
        end
        done = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        done = 1'b0; req = 4'b1111;
        tick();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_gap: gnt=%b, want 0000", gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL single_ptr_rotated: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
        end
        done = 1'b1;
        tick();
        done = 1'b0; req = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            want = '0;
            want[i % N] = 1'b1;
            tick();
            n_checks++;
            if (gnt !== want) begin
                n_fail++;
                $display("FAIL fairness_order[%0d]: gnt=%b, want %b", i, gnt, want);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL fairness_release[%0d]: gnt=%b, want 0000", i, gnt);
            end
            tick();
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL fairness_gap[%0d]: gnt=%b, want 0000", i, gnt);
            end
        end
        req = '0;
    endtask

    task automatic test_wrap_withdraw();
        req = 4'b0010;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_setup: gnt=%b, want 0010", gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0; req = 4'b0011;
        tick();
        tick();
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_pick: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
        req = 4'b0010;
        tick();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        req = 4'b1111;
        tick();
        tick();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL withdraw_ptr: gnt=%b, want 0010", gnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_grant: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ptr_bit0: gnt=%b, want 0001", gnt);
        end
        done = 1'b1; req = 4'b0010;
        tick();
        done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_regrant: gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_hold_limit();
        int held;
        req = 4'b0001;
        tick();
        held = 0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 40 && gnt === 4'b0001; c++) begin
            held++;
            n_checks++;
            if (timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early: timeout=%b at held=%0d, want 0", timeout, held);
            end
            tick();
        end
        n_checks++;
        if (held != MAX_HOLD || gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_release: held=%0d gnt=%b to=%b, want %0d/0000/1", held, gnt, timeout, MAX_HOLD);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width: timeout=%b, want 0", timeout);
        end
`else
        for (int c = 0; c < 40; c++) begin
            if (gnt === 4'b0001 && timeout === 1'b0) held++;
            tick();
        end
        n_checks++;
        if (held != 40 || gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_indefinite: held=%0d gnt=%b to=%b, want 40/0001/0", held, gnt, timeout);
        end
`endif
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 60) == 0);
            tick();
            n_checks++;
            if (gnt !== exp_gnt() || busy !== m_busy || timeout !== m_to ||
                (m_busy && gnt_id !== 2'(m_win))) begin
                n_fail++;
                $display("FAIL random[%0d]: gnt=%b busy=%b id=%0d to=%b, want %b/%b/%0d/%b",
                         i, gnt, busy, gnt_id, timeout, exp_gnt(), m_busy, m_win, m_to);
            end
        end
        rst = 1'b0; done = 1'b0; req = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_ptr = 0; m_win = 0; m_hold = 0; m_busy = 1'b0; m_gap = 1'b0; m_to = 1'b0;
        rst = 1'b1; req = '0; done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap_withdraw();
        test_reset_mid_grant();
        test_hold_limit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
